// File: rtl/seq_pkg.sv
// seq_pkg: FSM encoding and default stream/pattern geometry shared by the generator and detector
package seq_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
    localparam int SEQ_WORD_W = 8;
    localparam int SEQ_PAT_W = 4;
    localparam logic [SEQ_PAT_W-1:0] SEQ_PATTERN = 4'b1011;
endpackage

// File: rtl/seq_pat_match.sv
// seq_pat_match: tracks valid bits in a history register, flags PATTERN and counts hits with saturation
module seq_pat_match
    import seq_pkg::*;
#(
    parameter int PAT_W = SEQ_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = SEQ_PATTERN,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_vld,
    input  logic             bit_in,
    output logic             pat_hit,
    output logic [CNT_W-1:0] pat_cnt
);
    localparam int FW = $clog2(PAT_W + 1);
    logic [PAT_W-1:0] hist, hist_n;
    logic [FW-1:0] fill;
    always_comb hist_n = {hist[PAT_W-2:0], bit_in};
    // fill keeps reset-cleared history from matching patterns that start with zeros
    always_ff @(posedge clk) begin
        if (rst) begin
            hist    <= '0;
            fill    <= '0;
            pat_hit <= 1'b0;
            pat_cnt <= '0;
        end else begin
            pat_hit <= bit_vld && fill >= FW'(PAT_W - 1) && hist_n == PATTERN;
            if (bit_vld) hist <= hist_n;
            if (bit_vld && fill != FW'(PAT_W)) fill <= fill + 1'b1;
            if (pat_hit && pat_cnt != '1) pat_cnt <= pat_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/seq_bitgen.sv
// seq_bitgen: shifts handshaked words out MSB-first with per-word idle gaps and a reference pattern matcher
module seq_bitgen
    import seq_pkg::*;
#(
    parameter int WORD_W = SEQ_WORD_W,
    parameter int GAP_W = 4,
    parameter int PAT_W = SEQ_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = SEQ_PATTERN,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              word_vld,
    output logic              word_rdy,
    input  logic [WORD_W-1:0] word_in,
    input  logic [GAP_W-1:0]  gap_in,
    output logic              dout,
    output logic              dout_vld,
    output logic              busy,
    output logic              pat_hit,
    output logic [CNT_W-1:0]  pat_cnt
);
    localparam int IW = $clog2(WORD_W + 1);
    state_t state, state_n;
    logic [WORD_W-1:0] hold_word, sh, sh_n;
    logic [GAP_W-1:0] hold_gap, gap_cnt, gap_n;
    logic [IW-1:0] idx, idx_n;
    logic hold_full, take, emit, bit_n, accept;
    assign accept = word_vld && word_rdy;
    assign word_rdy = !hold_full;
    assign busy = hold_full || state != IDLE;
    // end of a word (or of its gap) falls through to the load/idle decision, giving back-to-back words
    always_comb begin
        state_n = state;
        sh_n = sh;
        idx_n = idx;
        gap_n = gap_cnt;
        take = 1'b0;
        emit = 1'b0;
        bit_n = 1'b0;
        if (en) begin
            if (state == SHIFT && idx != IW'(WORD_W)) begin
                emit = 1'b1;
                bit_n = sh[WORD_W-1];
                sh_n = sh << 1;
                idx_n = idx + 1'b1;
            end else if (state == SHIFT && gap_cnt != '0) begin
                state_n = GAP;
                gap_n = gap_cnt - 1'b1;
            end else if (state == GAP && gap_cnt != '0) begin
                gap_n = gap_cnt - 1'b1;
            end else if (hold_full) begin
                take = 1'b1;
                emit = 1'b1;
                bit_n = hold_word[WORD_W-1];
                sh_n = hold_word << 1;
                idx_n = IW'(1);
                gap_n = hold_gap;
                state_n = SHIFT;
            end else begin
                state_n = IDLE;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sh        <= '0;
            idx       <= '0;
            gap_cnt   <= '0;
            hold_word <= '0;
            hold_gap  <= '0;
            hold_full <= 1'b0;
            dout      <= 1'b0;
            dout_vld  <= 1'b0;
        end else begin
            state     <= state_n;
            sh        <= sh_n;
            idx       <= idx_n;
            gap_cnt   <= gap_n;
            dout      <= bit_n;
            dout_vld  <= emit;
            hold_full <= accept || (hold_full && !take);
            if (accept) hold_word <= word_in;
            if (accept) hold_gap <= gap_in;
        end
    end
    seq_pat_match #(.PAT_W(PAT_W), .PATTERN(PATTERN), .CNT_W(CNT_W)) u_match (
        .clk     (clk),
        .rst     (rst),
        .bit_vld (emit),
        .bit_in  (bit_n),
        .pat_hit (pat_hit),
        .pat_cnt (pat_cnt)
    );
endmodule
